// File: rtl/data_mem_responder_pkg.sv
// Shared data-memory definitions: store types, MMIO register map, STATUS flags and lane struct.
// Pure declarations; no timing or flow-control behaviour lives here.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_WORD = 2'b00,
    ST_HALF = 2'b01,
    ST_BYTE = 2'b10,
    ST_RSVD = 2'b11
  } storetype_e;

  localparam logic [31:0] MMIO_BASE    = 32'hFFFF_FF00;
  localparam logic [7:0]  OFF_CYCLE    = 8'h00;
  localparam logic [7:0]  OFF_STATUS   = 8'h04;
  localparam logic [7:0]  OFF_STORECNT = 8'h08;
  localparam logic [7:0]  OFF_END      = 8'h0C;

  localparam int STATUS_MISALIGN = 0;
  localparam int STATUS_OOR      = 1;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] dat;
    logic        misalign;
  } lane_t;

  function automatic logic is_mmio(input logic [31:0] a);
    return (a[31:8] == MMIO_BASE[31:8]) && (a[7:0] < OFF_END);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-data-memory bus: address, store data/type/request and combinational read data.
// Zero-latency reads, single-cycle stores; no backpressure, the memory always accepts.
interface data_mem_responder_if import dmem_pkg::*; ();

  logic [31:0] A;
  logic [31:0] WD;
  logic        WE;
  storetype_e  Storetype;
  logic [31:0] RD;

  modport master (output A, WD, WE, Storetype, input RD);
  modport slave  (input A, WD, WE, Storetype, output RD);

endinterface

// File: rtl/data_mem_responder_byte_lane_gen.sv
// Maps store type and low address bits to byte enables, lane-replicated data and a misalign flag.
// Purely combinational; no backpressure.
module byte_lane_gen import dmem_pkg::*; (
  input  storetype_e  st,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  output lane_t       lane
);

  always_comb begin
    lane          = '0;
    lane.dat      = wd;
    lane.misalign = 1'b0;
    unique case (st)
      ST_WORD: begin
        lane.be       = 4'hF;
        lane.misalign = (addr_lo != 2'b00);
      end
      ST_HALF: begin
        lane.be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane.dat      = {2{wd[15:0]}};
        lane.misalign = addr_lo[0];
      end
      ST_BYTE: begin
        lane.be  = 4'b0001 << addr_lo;
        lane.dat = {4{wd[7:0]}};
      end
      // Reserved store type is reported through the same flag as misalignment.
      default: lane.misalign = 1'b1;
    endcase
    if (lane.misalign) lane.be = 4'b0000;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data RAM with per-byte stores plus CYCLE/STATUS/STORECNT MMIO registers.
// Reads are combinational (0 cycles), stores commit on the next rising edge; never stalls the core.
module data_mem_responder import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 256
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      cycle_q;
  logic [31:0]      storecnt_q;
  logic [1:0]       status_q;
  lane_t            lane;
  logic             in_ram;
  logic             in_mmio;
  logic             commit;
  logic             status_wr;
  logic [1:0]       set_vec;
  logic [1:0]       clr_vec;
  logic [IDX_W-1:0] idx;
  logic [7:0]       off;

  byte_lane_gen u_lane (
    .st      (bus.Storetype),
    .addr_lo (bus.A[1:0]),
    .wd      (bus.WD),
    .lane    (lane)
  );

  assign in_ram  = ({1'b0, bus.A} < RAM_BYTES);
  assign in_mmio = is_mmio(bus.A);
  assign idx     = bus.A[IDX_W+1:2];
  assign off     = {bus.A[7:2], 2'b00};

  assign commit    = bus.WE && in_ram && !lane.misalign;
  assign status_wr = bus.WE && (bus.Storetype == ST_WORD) && !lane.misalign
                     && in_mmio && (off == OFF_STATUS);
  assign clr_vec   = status_wr ? bus.WD[1:0] : 2'b00;

  // Misalignment outranks out-of-range, so only one flag is raised per bad store.
  assign set_vec[STATUS_MISALIGN] = bus.WE && lane.misalign;
  assign set_vec[STATUS_OOR]      = bus.WE && !lane.misalign && !in_ram && !in_mmio;

  always_ff @(posedge clk) begin
    if (rst && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lane.be[b]) mem[idx][8*b +: 8] <= lane.dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q    <= '0;
      status_q   <= '0;
      storecnt_q <= '0;
    end else begin
      cycle_q  <= cycle_q + 32'd1;
      status_q <= (status_q & ~clr_vec) | set_vec;
      if (commit && (storecnt_q != '1)) storecnt_q <= storecnt_q + 32'd1;
    end
  end

  always_comb begin
    bus.RD = '0;
    if (in_ram) begin
      bus.RD = mem[idx];
    end else if (in_mmio) begin
      case (off)
        OFF_CYCLE:    bus.RD = cycle_q;
        OFF_STATUS:   bus.RD = {30'b0, status_q};
        OFF_STORECNT: bus.RD = storecnt_q;
        default:      bus.RD = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: stores, lanes, MMIO flags, reset and CYCLE wrap.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam logic [31:0] A_CYC = 32'hFFFF_FF00;
  localparam logic [31:0] A_STS = 32'hFFFF_FF04;
  localparam logic [31:0] A_CNT = 32'hFFFF_FF08;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH_WORDS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input storetype_e t);
    @(negedge clk);
    bus.A = a; bus.WD = d; bus.Storetype = t; bus.WE = 1'b1;
    @(negedge clk);
    bus.WE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.WE = 1'b0; bus.A = a;
    #1;
    chk(tag, bus.RD, exp);
  endtask

  initial begin
    rst = 1'b0;
    bus.A = '0; bus.WD = '0; bus.WE = 1'b0; bus.Storetype = ST_WORD;
    repeat (2) @(negedge clk);
    rd_chk("reset_cycle", A_CYC, 32'h0);
    rd_chk("reset_status", A_STS, 32'h0);
    rd_chk("reset_storecnt", A_CNT, 32'h0);

    // Ten rising edges after release.
    @(negedge clk); rst = 1'b1;
    repeat (9) @(negedge clk);
    rd_chk("cycle_after_10", A_CYC, 32'd10);

    st(32'h10, 32'h1122_3344, ST_WORD);
    st(32'h12, 32'h0000_00AA, ST_BYTE);
    rd_chk("sw_sb_word", 32'h10, 32'h11AA_3344);
    rd_chk("read_ignores_lo", 32'h13, 32'h11AA_3344);
    rd_chk("storecnt_2", A_CNT, 32'd2);

    st(32'h20, 32'h0, ST_WORD);
    st(32'h04, 32'hCAFE_F00D, ST_WORD);
    st(32'h06, 32'h1, ST_WORD);
    rd_chk("misalign_flag", A_STS, 32'h1);
    rd_chk("storecnt_4", A_CNT, 32'd4);
    rd_chk("misalign_nowrite", 32'h04, 32'hCAFE_F00D);

    // Reset coinciding with a store: registers clear, store is suppressed.
    @(negedge clk);
    rst = 1'b0;
    bus.A = 32'h4; bus.WD = 32'h5555_5555; bus.Storetype = ST_WORD; bus.WE = 1'b1;
    @(negedge clk);
    bus.WE = 1'b0;
    rd_chk("rst_st_cycle", A_CYC, 32'h0);
    rd_chk("rst_st_status", A_STS, 32'h0);
    rd_chk("rst_st_storecnt", A_CNT, 32'h0);
    rd_chk("rst_st_ram_kept", 32'h4, 32'hCAFE_F00D);
    @(negedge clk); rst = 1'b1;

    st(32'h22, 32'h0000_BEEF, ST_HALF);
    st(32'h21, 32'hDEAD_BEEF, ST_WORD);
    rd_chk("sh_upper_word", 32'h20, 32'hBEEF_0000);
    rd_chk("sh_sw_status", A_STS, 32'h1);
    rd_chk("sh_sw_storecnt", A_CNT, 32'd1);

    st(A_STS, 32'h3, ST_WORD);
    rd_chk("status_cleared", A_STS, 32'h0);
    st(32'h8000, 32'h1234_5678, ST_WORD);
    rd_chk("oor_status", A_STS, 32'h2);
    rd_chk("oor_read_zero", 32'h8000, 32'h0);

    st(32'h3FC, 32'h0BAD_F00D, ST_WORD);
    rd_chk("last_word", 32'h3FC, 32'h0BAD_F00D);
    rd_chk("storecnt_after_last", A_CNT, 32'd2);
    st(A_STS, 32'h2, ST_WORD);
    st(32'h400, 32'h1, ST_WORD);
    rd_chk("first_oor_status", A_STS, 32'h2);
    rd_chk("first_oor_read", 32'h400, 32'h0);

    st(32'h23, 32'h0, ST_HALF);
    rd_chk("status_3", A_STS, 32'h3);
    st(A_STS, 32'h1, ST_WORD);
    rd_chk("w1c_bit0", A_STS, 32'h2);

    st(32'h23, 32'h0, ST_HALF);
    @(negedge clk);
    bus.A = 32'h1; bus.WD = 32'h0; bus.Storetype = ST_WORD; bus.WE = 1'b1;
    force dut.clr_vec = 2'b01;
    @(negedge clk);
    bus.WE = 1'b0;
    release dut.clr_vec;
    rd_chk("set_beats_clear", A_STS, 32'h3);

    st(A_STS, 32'h3, ST_WORD);
    st(32'h10, 32'hFFFF_FFFF, ST_RSVD);
    rd_chk("rsvd_status", A_STS, 32'h1);
    rd_chk("rsvd_nowrite", 32'h10, 32'h11AA_3344);
    rd_chk("rsvd_storecnt", A_CNT, 32'd2);

    st(A_STS, 32'h1, ST_HALF);
    rd_chk("half_to_status_ignored", A_STS, 32'h1);
    st(A_STS, 32'h1, ST_WORD);
    st(A_CNT, 32'h0, ST_WORD);
    st(A_CYC, 32'h0, ST_WORD);
    rd_chk("ro_regs_no_flag", A_STS, 32'h0);
    rd_chk("storecnt_not_written", A_CNT, 32'd2);
    rd_chk("read_ff0c", 32'hFFFF_FF0C, 32'h0);
    rd_chk("read_top", 32'hFFFF_FFFC, 32'h0);
    rd_chk("reads_no_flag", A_STS, 32'h0);
    st(32'hFFFF_FF10, 32'h0, ST_WORD);
    rd_chk("store_ff10_oor", A_STS, 32'h2);

    st(32'h13, 32'h0000_0077, ST_BYTE);
    st(32'h10, 32'h0000_5566, ST_HALF);
    rd_chk("lanes_b3_h0", 32'h10, 32'h77AA_5566);
    rd_chk("storecnt_4b", A_CNT, 32'd4);

    @(negedge clk);
    bus.WE = 1'b0; bus.A = A_CYC;
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    chk("wrap_fffe", bus.RD, 32'hFFFF_FFFE);
    release dut.cycle_q;
    @(negedge clk); #1;
    chk("wrap_ffff", bus.RD, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    chk("wrap_zero", bus.RD, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit RAM words; RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 A  input  32  byte address (core ALUResult).
REQ-005 WD  input  32  store data, right-aligned (core WriteData).
REQ-006 WE  input  1  store request for the current cycle (core MemWrite).
REQ-007 Storetype  input  2  00 word, 01 half, 10 byte, 11 reserved.
REQ-008 RD  output  32  combinational read word (core ReadData); the core performs load extraction.

Function
REQ-009 RAM reads SHALL return the full word at A[31:2], ignoring A[1:0], with zero cycles of latency.
REQ-010 RAM stores SHALL commit on the rising edge where WE=1, rst=1, the address is in RAM and the store is aligned; the new data is visible on RD in the following cycle.
REQ-011 Byte lanes are little-endian.
  - Word store: writes lanes 3..0 with WD.
  - Half store: writes lanes {A[1]*2+1, A[1]*2} with WD[15:0].
  - Byte store: writes lane A[1:0] with WD[7:0].
  - Other lanes: unchanged.
REQ-012 A store is misaligned for Storetype 00 with A[1:0]!=0, or Storetype 01 with A[0]=1; a misaligned store SHALL write nothing and set STATUS[0].
REQ-013 Storetype 11 with WE=1 SHALL write nothing and set STATUS[0].
REQ-014 MMIO window at 0xFFFF_FF00..0xFFFF_FF0B SHALL decode as follows:
  - CYCLE (FF00): read-only.
  - STATUS (FF04): read / write-1-to-clear.
  - STORECNT (FF08): read-only.
REQ-015 Addresses outside both RAM and the MMIO window:
  - Reads SHALL return 0.
  - Stores SHALL write nothing and set STATUS[1].
  - Misalignment takes priority: only STATUS[0] is set.
REQ-016 Reads within the MMIO window SHALL return the register at {A[31:2],2'b00}.
REQ-017 Reads of FF0C..FFFF_FFFF SHALL return 0 without setting any flag.
REQ-018 CYCLE SHALL increment by 1 every cycle and wrap from 0xFFFF_FFFF to 0; a read returns the pre-increment value.
REQ-019 STATUS[31:2] SHALL read 0. An aligned word store to FF04 SHALL clear each flag whose WD bit is 1.
REQ-020 If a flag-set condition and a clear occur in the same cycle, the set SHALL win.
REQ-021 STORECNT SHALL increment once per committed RAM store and saturate at 0xFFFF_FFFF.
REQ-022 Stores to CYCLE or STORECNT, and non-word stores to STATUS, SHALL be ignored without raising a flag.

Reset
REQ-023 With rst=0 at a rising edge:
  - CYCLE, STATUS and STORECNT SHALL become 0.
  - Any concurrent store SHALL be suppressed.
REQ-024 RAM contents SHALL NOT be reset.
REQ-025 RD remains combinational during reset and reflects the register values after reset.

Structure
REQ-026 Shared package dmem_pkg SHALL hold:
  - the Storetype enum (ST_WORD, ST_HALF, ST_BYTE, ST_RSVD);
  - the MMIO base and offsets;
  - the STATUS bit indices (MISALIGN=0, OOR=1).
The core's control unit uses the same Storetype enum.
REQ-027 One sub-module, byte_lane_gen, SHALL map (Storetype, A[1:0], WD) to a 4-bit byte enable, lane-replicated write data and a misalign flag.
REQ-028 The RAM SHALL be inferable as a single word array with per-byte write enables.

Verification
REQ-029 SW 0x11223344 to A=0x10, then SB 0xAA to A=0x12 -> RD at 0x10 = 0x11AA3344; STORECNT = 2.
REQ-030 SH 0xBEEF to A=0x22, then SW 0xDEADBEEF to A=0x21 ->
  - word 0x20 = 0xBEEF0000 (upper half written, lower half unchanged from its initial 0);
  - STATUS = 0x1;
  - STORECNT = 1.
REQ-031 SW to A=0x0000_8000 (DEPTH_WORDS=256) -> STATUS = 0x2, no RAM change, read of A=0x8000 = 0.
REQ-032 With STATUS=0x3, SW WD=0x1 to 0xFFFF_FF04 -> STATUS = 0x2. A same-cycle misaligned store is not possible, so a separate test forces a set and a clear of bit 0 in one cycle -> bit 0 remains 1.
REQ-033 Release reset, then read CYCLE after 10 cycles -> 10. Assert rst=0 together with WE=1 SW to 0x4 -> CYCLE=0, STATUS=0, STORECNT=0, word 0x4 unchanged.
REQ-034 Preload CYCLE near wrap via hierarchical force at 0xFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0 on successive cycles.
